// File: rtl/image_streamer.sv
// ---------------------------------------------------------------------------
// image_streamer
//   Reads one frame of pixels from an image memory, which returns data one
//   cycle after each read strobe. It pushes them in address order into a
//   downstream RGB fifo, respecting the fifo_full backpressure.
//
//   A 2-entry in-order buffer sits between the memory and the fifo. This
//   gives 1 pixel/cycle throughput while fifo_full is low. Under any
//   backpressure pattern, no pixel is lost or duplicated.
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   start                frame start request (honoured only in IDLE)
//   busy                 high while a frame is in progress
//   done                 one-cycle pulse when the last pixel is written
//   mem_rd_en, mem_addr  image memory read strobe / address
//   mem_rd_data          read data, valid the cycle after mem_rd_en
//   fifo_wr_en, fifo_din write strobe / pixel into the downstream fifo
//   fifo_full            downstream fifo full
// ---------------------------------------------------------------------------
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | issuing reads and draining the buffer into the fifo
//   S_DONE | one-cycle done pulse, then back to S_IDLE
// ---------------------------------------------------------------------------
module image_streamer #(
    parameter int DWIDTH     = 24,
    parameter int AWIDTH     = 20,
    parameter int NUM_PIXELS = 720*540
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rd_data,
    output logic              fifo_wr_en,
    output logic [DWIDTH-1:0] fifo_din,
    input  logic              fifo_full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AWIDTH-1:0] NUM_PIX  = AWIDTH'(NUM_PIXELS);
    localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(NUM_PIXELS - 1);

    state_t              state;
    logic [AWIDTH-1:0]   rd_addr;
    logic [AWIDTH-1:0]   last_addr;
    logic [AWIDTH-1:0]   wr_count;
    logic [DWIDTH-1:0]   buf_q [2];
    logic                head;
    logic [1:0]          count;
    logic                in_flight;
    logic [1:0]          pending;
    logic                wr_slot;

    always_comb begin
        fifo_wr_en = (state == S_RUN) && (count != 2'd0) && !fifo_full;
        fifo_din   = buf_q[head];
        // Slots that will be occupied next cycle if no new read is issued.
        // count <= 2, so this never exceeds 3, and a pop implies count >= 1.
        pending    = count + {1'b0, in_flight} - {1'b0, fifo_wr_en};
        mem_rd_en  = (state == S_RUN) && (rd_addr < NUM_PIX) && (pending < 2'd2);
        // The address is presented live during a read and holds the last
        // issued address otherwise.
        mem_addr   = mem_rd_en ? rd_addr : last_addr;
        // The capture goes into the slot behind the oldest entry.
        wr_slot    = head ^ count[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= '0;
            last_addr <= '0;
            wr_count  <= '0;
            head      <= 1'b0;
            count     <= 2'd0;
            in_flight <= 1'b0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else begin
            // Clearing in_flight on reset drops data that returns in the
            // cycle after an aborted frame.
            in_flight <= mem_rd_en;

            if (mem_rd_en) begin
                rd_addr   <= rd_addr + 1'b1;
                last_addr <= rd_addr;
            end

            if (in_flight) begin
                buf_q[wr_slot] <= mem_rd_data;
            end

            if (fifo_wr_en) begin
                head <= ~head;
            end

            case ({in_flight, fifo_wr_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        rd_addr  <= '0;
                        wr_count <= '0;
                    end
                end
                S_RUN: begin
                    if (fifo_wr_en) begin
                        wr_count <= wr_count + 1'b1;
                        if (wr_count == LAST_PIX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// ---------------------------------------------------------------------------
// tb_image_streamer
//   Four instances of image_streamer with NUM_PIXELS = 4, 8, 16 and 1 share
//   one clock. Each instance has its own memory model, where mem[a] equals
//   24'h000100*a + a.
//   Instance 0 is checked cycle by cycle against a table. The other frames
//   go through a per-cycle scoreboard (run_frame).
// ---------------------------------------------------------------------------
module tb_image_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        rst_v;
    logic [3:0]        start_v;
    logic [3:0]        full_v;
    logic [3:0]        busy_v;
    logic [3:0]        done_v;
    logic [3:0]        rd_v;
    logic [3:0]        wr_v;
    logic [3:0][19:0]  addr_v;
    logic [3:0][23:0]  rdd_v;
    logic [3:0][23:0]  din_v;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [23:0] pix(input int a);
        return 24'(a * 256 + a);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NPG = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 16 : 1;
        image_streamer #(
            .DWIDTH    (24),
            .AWIDTH    (20),
            .NUM_PIXELS(NPG)
        ) u_dut (
            .clock      (clk),
            .reset      (rst_v[g]),
            .start      (start_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .mem_rd_en  (rd_v[g]),
            .mem_addr   (addr_v[g]),
            .mem_rd_data(rdd_v[g]),
            .fifo_wr_en (wr_v[g]),
            .fifo_din   (din_v[g]),
            .fifo_full  (full_v[g])
        );
    end

    // The memory answers one cycle after each read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_v[i]) rdd_v[i] <= pix(int'(addr_v[i]));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk({tag, "_busy"},  int'(busy_v[g]), 0);
        chk({tag, "_done"},  int'(done_v[g]), 0);
        chk({tag, "_rd_en"}, int'(rd_v[g]),   0);
        chk({tag, "_wr_en"}, int'(wr_v[g]),   0);
        chk({tag, "_addr"},  int'(addr_v[g]), 0);
        chk({tag, "_din"},   int'(din_v[g]),  0);
    endtask

    // mode 0: fifo never full, 1: full in cycles 4-9, 2: random 50% full,
    // 3: start held high throughout. Cycle 0 is the cycle that drives start.
    task automatic run_frame(input int g, input int np, input int mode);
        int  rd_i = 0;
        int  wr_i = 0;
        int  dn   = 0;
        bit  fin  = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(posedge clk); #1;
            start_v[g] = (c == 0) || (mode == 3);
            case (mode)
                1:       full_v[g] = (c >= 4 && c <= 9);
                2:       full_v[g] = 1'($urandom_range(0, 1));
                default: full_v[g] = 1'b0;
            endcase
            @(negedge clk);
            if (wr_v[g]) begin
                chk("wr_while_full", int'(full_v[g]), 0);
                chk("pixel_data", int'(din_v[g]), int'(pix(wr_i)));
                wr_i++;
            end
            if (rd_v[g]) begin
                chk("rd_addr", int'(addr_v[g]), rd_i);
                rd_i++;
            end
            chk("reads_ahead_le2", int'((rd_i - wr_i) <= 2), 1);
            if (done_v[g]) begin
                dn++;
                chk("busy_in_done", int'(busy_v[g]), 0);
                fin = 1;
            end
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: inst %0d no done pulse within 300 cycles", g);
        end
        chk("pixels_written", wr_i, np);
        chk("reads_issued", rd_i, np);
        chk("done_pulses", dn, 1);
        @(posedge clk); #1;
        full_v[g] = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", int'(done_v[g]), 0);
        chk("idle_after_done", int'(busy_v[g]), 0);
    endtask

    typedef struct {
        logic        start;
        logic        busy;
        logic        done;
        logic        rd;
        logic [19:0] addr;
        logic        wr;
        logic [23:0] din;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 20'd0, 1'b0, 24'h000000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 20'd0, 1'b0, 24'h000000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 20'd1, 1'b0, 24'h000000};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 20'd2, 1'b1, 24'h000000};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 20'd3, 1'b1, 24'h000101};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 20'd3, 1'b1, 24'h000202};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 20'd3, 1'b1, 24'h000303};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 20'd3, 1'b0, 24'h000000};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 20'd3, 1'b0, 24'h000000};

        rst_v   = 4'hF;
        start_v = 4'h0;
        full_v  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_v = 4'h0;
        @(negedge clk);
        for (int g = 0; g < 4; g++) chk_zero(g, "reset");

        // NUM_PIXELS=4, exact cycle-by-cycle timing.
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            start_v[0] = tbl[c].start;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", c),  int'(busy_v[0]), int'(tbl[c].busy));
            chk($sformatf("tbl%0d_done", c),  int'(done_v[0]), int'(tbl[c].done));
            chk($sformatf("tbl%0d_rd_en", c), int'(rd_v[0]),   int'(tbl[c].rd));
            chk($sformatf("tbl%0d_addr", c),  int'(addr_v[0]), int'(tbl[c].addr));
            chk($sformatf("tbl%0d_wr_en", c), int'(wr_v[0]),   int'(tbl[c].wr));
            if (tbl[c].wr) chk($sformatf("tbl%0d_din", c), int'(din_v[0]), int'(tbl[c].din));
        end

        // Start held high: exactly one frame, then a restart from IDLE.
        run_frame(0, 4, 3);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("restart_busy", int'(busy_v[0]), 1);
        chk("restart_rd_en", int'(rd_v[0]), 1);
        chk("restart_addr", int'(addr_v[0]), 0);
        begin
            bit seen = 0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                seen = done_v[0];
            end
            chk("restart_frame_done", int'(seen), 1);
        end
        @(negedge clk);

        // NUM_PIXELS=8 with fifo_full held in cycles 4-9.
        run_frame(1, 8, 1);

        // Reset in cycle 3 of a NUM_PIXELS=8 frame.
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            start_v[1] = (c == 0);
            rst_v[1]   = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                chk("pre_abort_wr_en", int'(wr_v[1]), 1);
                chk("pre_abort_din", int'(din_v[1]), int'(pix(0)));
            end
            if (c >= 4) chk_zero(1, $sformatf("abort_c%0d", c));
        end
        run_frame(1, 8, 0);

        // NUM_PIXELS=16 with random backpressure.
        run_frame(2, 16, 2);

        // NUM_PIXELS=1, twice.
        run_frame(3, 1, 0);
        run_frame(3, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 SHALL have parameter DWIDTH, default 24, pixel width in bits (RGB, 8 bits per channel).
REQ-002 SHALL have parameter AWIDTH, default 20, memory address width.
REQ-003 SHALL have parameter NUM_PIXELS, default 720*540, pixels per frame; SHALL be >= 1 and < 2^AWIDTH.
REQ-004 SHALL have port clock, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, frame start request.
REQ-007 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when a frame completes.
REQ-009 SHALL have port mem_rd_en, output, 1, image memory read strobe.
REQ-010 SHALL have port mem_addr, output, AWIDTH, image memory read address.
REQ-011 SHALL have port mem_rd_data, input, DWIDTH, read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port fifo_wr_en, output, 1, write strobe into the downstream RGB fifo.
REQ-013 SHALL have port fifo_din, output, DWIDTH, pixel written to the fifo.
REQ-014 SHALL have port fifo_full, input, 1, downstream fifo full.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 IDLE: start=1 SHALL move the block to RUN, clear the read address and the written-pixel count to 0, and set busy=1 from the next cycle.
REQ-017 RUN: mem_rd_en SHALL be asserted whenever read address < NUM_PIXELS and (buffered pixels + reads in flight - pixels written this cycle) < 2.
REQ-018 Each mem_rd_en cycle SHALL present mem_addr = current read address, then increment the read address by 1.
REQ-019 Read data SHALL be captured into a 2-entry in-order output buffer on the clock edge ending the cycle after mem_rd_en.
REQ-020 fifo_wr_en SHALL equal (buffer non-empty AND NOT fifo_full), with fifo_din = the oldest buffered pixel; fifo_wr_en SHALL never be asserted while fifo_full=1.
REQ-021 A pixel SHALL be popped from the buffer only on a cycle where fifo_wr_en=1.
REQ-022 Capture and pop in the same cycle SHALL leave buffer occupancy unchanged and preserve order.
REQ-023 Pixels SHALL reach the fifo in address order 0..NUM_PIXELS-1, each exactly once, with no drops or duplicates under any fifo_full pattern.
REQ-024 With fifo_full=0 throughout, sustained throughput SHALL be 1 pixel per cycle.
REQ-025 Latency: start sampled in cycle N -> mem_rd_en/mem_addr=0 in cycle N+1 -> fifo_wr_en with pixel 0 in cycle N+3 (fifo not full).
REQ-026 RUN SHALL move to DONE on the cycle the NUM_PIXELS-th pixel is written.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, with busy=0 in that cycle, then return to IDLE.
REQ-028 start SHALL be ignored in RUN and DONE.
REQ-029 NUM_PIXELS=1 SHALL issue exactly one read and one write, then pulse done.
REQ-030 mem_addr SHALL hold its last value when mem_rd_en=0.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE; clear the read address, pixel count, buffer occupancy and in-flight flag; and set busy=0, done=0, mem_rd_en=0, fifo_wr_en=0, mem_addr=0, fifo_din=0.
REQ-032 Reset in RUN SHALL abort the frame; read data returning in the cycle after reset SHALL be discarded.
REQ-033 reset SHALL take priority over start in the same cycle.

Verification
REQ-034 NUM_PIXELS=4, mem[i]=24'h000100*i+i, fifo_full=0, start pulse in cycle 0 -> mem_rd_en in cycles 1-4 (addr 0-3), fifo_wr_en in cycles 3-6 with the matching data, done=1 in cycle 7, busy=1 in cycles 1-6.
REQ-035 NUM_PIXELS=8, fifo_full held 1 in cycles 4-9 -> fifo_wr_en=0 in cycles 4-9, at most 2 reads beyond the last write, all 8 pixels written in order, no loss.
REQ-036 NUM_PIXELS=16, pseudo-random fifo_full at 50% duty -> scoreboard matches 16 pixels in address order, exactly one done pulse.
REQ-037 NUM_PIXELS=1 -> single mem_rd_en with addr 0, single fifo_wr_en, done pulse, return to IDLE; a second start then repeats the frame from addr 0.
REQ-038 Reset asserted in cycle 3 of a NUM_PIXELS=8 frame -> all outputs 0 from cycle 4 onward, no fifo_wr_en until a new start, and the new frame restarts at addr 0.
REQ-039 start held high for the whole frame -> only one frame runs; a new frame begins only if start is still high in IDLE after done.
